alu_flag_unit: RTL

Sequential consumer of the 32-bit ALU's condition outputs (zero, carry, negative, overflow). It sits in the execute stage directly behind the ALU. It decodes which flags are meaningful for the issued aluc, keeps a registered status word, resolves branch conditions one cycle later, and raises a held, acknowledged overflow exception request toward CP0 together with the faulting PC.

---
 rtl/alu_flag_unit_pkg.sv | 36 +++
 rtl/alu_flag_unit_valid.sv | 24 ++
 rtl/alu_flag_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_flag_unit_pkg.sv
// Shared definitions for the ALU flag unit: aluc codes, branch selectors,
// exception FSM states and the default overflow exception code.
package alu_flag_unit_pkg;

    localparam logic [3:0] ALUC_ADDU = 4'b0000;
    localparam logic [3:0] ALUC_SUBU = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0011;
    localparam logic [3:0] ALUC_AND  = 4'b0100;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0110;
    localparam logic [3:0] ALUC_NOR  = 4'b0111;
    localparam logic [3:0] ALUC_LUI  = 4'b1000;
    localparam logic [3:0] ALUC_SLTU = 4'b1010;
    localparam logic [3:0] ALUC_SLT  = 4'b1011;
    localparam logic [3:0] ALUC_SRA  = 4'b1100;
    localparam logic [3:0] ALUC_SRL  = 4'b1101;
    localparam logic [3:0] ALUC_SLA  = 4'b1110;
    localparam logic [3:0] ALUC_SLL  = 4'b1111;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLTZ = 3'd2;
    localparam logic [2:0] BR_BGEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BLEZ = 3'd5;
    localparam logic [2:0] BR_BLTU = 3'd6;

    localparam logic [4:0] EXC_OV_DEF = 5'd12;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

endpackage

// File: rtl/alu_flag_unit_valid.sv
// Combinational decode of aluc into carry/overflow flag validity.
// Module name kept as alu_flag_valid so the hazard unit can share it.
module alu_flag_valid
    import alu_flag_unit_pkg::*;
(
    input  logic [3:0] aluc,
    output logic       c_valid,
    output logic       v_valid
);

    always_comb begin
        c_valid = 1'b0;
        v_valid = 1'b0;
        case (aluc)
            ALUC_ADDU, ALUC_SUBU, ALUC_SLTU,
            ALUC_SRA, ALUC_SRL, ALUC_SLA, ALUC_SLL: c_valid = 1'b1;
            ALUC_ADD, ALUC_SUB:                     v_valid = 1'b1;
            ALUC_AND, ALUC_OR, ALUC_XOR, ALUC_NOR,
            ALUC_LUI, ALUC_SLT:                     ;
            default:                                ;
        endcase
    end

endmodule

// File: rtl/alu_flag_unit.sv
// Execute-stage flag consumer: registered {N,Z,C,V} status, branch resolution
// and held overflow exception request. Optional ALU_FLAG_OVF_CNT_EN adds ovf_count.
module alu_flag_unit
    import alu_flag_unit_pkg::*;
#(
    parameter logic [4:0]  EXC_OV = EXC_OV_DEF,
    parameter int unsigned PC_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [3:0]      aluc,
    input  logic            zero,
    input  logic            carry,
    input  logic            negative,
    input  logic            overflow,
    input  logic [PC_W-1:0] pc,
    input  logic            br_check,
    input  logic [2:0]      br_type,
    input  logic            trap_en,
    input  logic            exc_ack,
    output logic [3:0]      status,
    output logic            br_valid,
    output logic            br_taken,
    output logic            exc_req,
    output logic [4:0]      exc_code,
    output logic [PC_W-1:0] exc_epc,
    output logic            stall
`ifdef ALU_FLAG_OVF_CNT_EN
    ,
    output logic [7:0]      ovf_count
`endif
);

    state_t state;
    logic   c_valid;
    logic   v_valid;
    logic   accept;
    logic   fault;
    logic   br_cond;

    alu_flag_valid u_flag_valid (
        .aluc    (aluc),
        .c_valid (c_valid),
        .v_valid (v_valid)
    );

    assign stall  = (state == ST_REQ);
    assign accept = alu_valid && !stall;
    assign fault  = accept && trap_en && overflow && v_valid;

    // Branches resolve on the raw ALU flags, not the retained status word.
    always_comb begin
        br_cond = 1'b0;
        case (br_type)
            BR_BEQ:  br_cond = zero;
            BR_BNE:  br_cond = !zero;
            BR_BLTZ: br_cond = negative;
            BR_BGEZ: br_cond = !negative;
            BR_BGTZ: br_cond = !negative && !zero;
            BR_BLEZ: br_cond = negative || zero;
            BR_BLTU: br_cond = carry && c_valid;
            default: br_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            status   <= '0;
            br_valid <= 1'b0;
            br_taken <= 1'b0;
            exc_req  <= 1'b0;
            exc_code <= '0;
            exc_epc  <= '0;
`ifdef ALU_FLAG_OVF_CNT_EN
            ovf_count <= '0;
`endif
        end else begin
            br_valid <= accept && br_check;
            if (accept) begin
                status[3] <= negative;
                status[2] <= zero;
                if (c_valid) status[1] <= carry;
                if (v_valid) status[0] <= overflow;
                if (br_check) br_taken <= br_cond;
            end
            case (state)
                ST_IDLE: begin
                    if (fault) begin
                        state    <= ST_REQ;
                        exc_req  <= 1'b1;
                        exc_code <= EXC_OV;
                        exc_epc  <= pc;
                    end
                end
                ST_REQ: begin
                    if (exc_ack) begin
                        state   <= ST_IDLE;
                        exc_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    exc_req <= 1'b0;
                end
            endcase
`ifdef ALU_FLAG_OVF_CNT_EN
            if (accept && v_valid && overflow && (ovf_count != 8'hFF))
                ovf_count <= ovf_count + 8'd1;
`endif
        end
    end

endmodule
